pipe_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_ctrl_hazard_cmp.sv | 34 +++
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode constants, state encoding, PC-select encodings and decode helpers
// for the five-stage pipeline controller.
package pipe_pkg;

    localparam int REG_MAX_W = 32;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;
    localparam logic [5:0] OP_NOP = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZ    = 2'd1,
        ST_REDIR  = 2'd2,
        ST_FREEZE = 2'd3
    } state_e;

    localparam logic [1:0] PC_SEL_NPC = 2'b00;
    localparam logic [1:0] PC_SEL_BEQ = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    function automatic logic is_alu(input logic [5:0] op);
        return (op[5:3] == 3'b000) && (op[2:0] <= 3'd5);
    endfunction

    function automatic logic reads_rs(input logic [5:0] op);
        return is_alu(op) || (op == OP_SW) || (op == OP_LW) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return is_alu(op) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    // Non-writers report register 0, which never matches as a hazard.
    function automatic logic [REG_MAX_W-1:0] dest_of(input logic [5:0] op,
                                                     input logic [REG_MAX_W-1:0] rt,
                                                     input logic [REG_MAX_W-1:0] rd);
        if (is_alu(op)) begin
            return rd;
        end else if (op == OP_LW) begin
            return rt;
        end else begin
            return {REG_MAX_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Combinational read-after-write check of the ID source registers against the
// destinations held in the EX and MEM shadow slots.
module hazard_cmp
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              ex_v,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_v,
    input  logic [REG_AW-1:0] mem_dst,
    output logic              hazard
);

    function automatic logic src_match(input logic              used,
                                       input logic [REG_AW-1:0] src,
                                       input logic              v,
                                       input logic [REG_AW-1:0] dst);
        return used && v && (src != {REG_AW{1'b0}}) && (src == dst);
    endfunction

    // Any used, non-zero source equal to a valid in-flight destination.
    always_comb begin
        hazard = src_match(use_rs, rs, ex_v,  ex_dst)  ||
                 src_match(use_rt, rt, ex_v,  ex_dst)  ||
                 src_match(use_rs, rs, mem_v, mem_dst) ||
                 src_match(use_rt, rt, mem_v, mem_dst);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: freeze > redirect > hazard > run.
// Optional saturating stall/flush counters are enabled with PIPE_CTRL_STATS_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              ife_ex,
    input  logic              mem_wait,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic [1:0]        pc_sel,
    output logic [1:0]        state_o
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              ex_v_r;
    logic [REG_AW-1:0] ex_dst_r;
    logic [5:0]        ex_op_r;
    logic              mem_v_r;
    logic [REG_AW-1:0] mem_dst_r;
    state_e            state_r;

    logic [REG_AW-1:0] id_dst_s;
    logic              hazard_s;
    logic              redirect_s;
    state_e            class_s;

    assign id_dst_s = REG_AW'(dest_of(op_id, REG_MAX_W'(rt_id), REG_MAX_W'(rd_id)));

    hazard_cmp #(
        .REG_AW (REG_AW)
    ) u_hazard_cmp (
        .rs      (rs_id),
        .rt      (rt_id),
        .use_rs  (reads_rs(op_id)),
        .use_rt  (reads_rt(op_id)),
        .ex_v    (ex_v_r),
        .ex_dst  (ex_dst_r),
        .mem_v   (mem_v_r),
        .mem_dst (mem_dst_r),
        .hazard  (hazard_s)
    );

    // Priority decision for this cycle; reset presents the run class.
    always_comb begin
        redirect_s = ex_v_r && ((ex_op_r == OP_JMP) || ((ex_op_r == OP_BEQ) && ife_ex));
        if (rst) begin
            class_s = ST_RUN;
        end else if (mem_wait) begin
            class_s = ST_FREEZE;
        end else if (redirect_s) begin
            class_s = ST_REDIR;
        end else if (hazard_s) begin
            class_s = ST_HAZ;
        end else begin
            class_s = ST_RUN;
        end
    end

    // Control outputs decoded from the chosen class.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        pc_sel      = PC_SEL_NPC;
        case (class_s)
            ST_FREEZE: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                exmem_we = 1'b0;
                memwb_we = 1'b0;
            end
            ST_REDIR: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pc_sel      = (ex_op_r == OP_JMP) ? PC_SEL_JMP : PC_SEL_BEQ;
            end
            ST_HAZ: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_sel = PC_SEL_NPC;
            end
        endcase
    end

    // Shadow slots advance on every unfrozen edge; the state records the class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_r    <= 1'b0;
            ex_dst_r  <= {REG_AW{1'b0}};
            ex_op_r   <= OP_NOP;
            mem_v_r   <= 1'b0;
            mem_dst_r <= {REG_AW{1'b0}};
            state_r   <= ST_RUN;
        end else begin
            state_r <= class_s;
            if (class_s != ST_FREEZE) begin
                mem_v_r   <= ex_v_r;
                mem_dst_r <= ex_dst_r;
                if (idex_bubble) begin
                    ex_v_r   <= 1'b0;
                    ex_dst_r <= {REG_AW{1'b0}};
                    ex_op_r  <= OP_NOP;
                end else begin
                    ex_v_r   <= 1'b1;
                    ex_dst_r <= id_dst_s;
                    ex_op_r  <= op_id;
                end
            end else begin
                mem_v_r <= mem_v_r;
                ex_v_r  <= ex_v_r;
            end
        end
    end

    assign state_o = state_r;

`ifdef PIPE_CTRL_STATS_EN
    // Saturating counters of hazard and redirect cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((class_s == ST_HAZ) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
            if ((class_s == ST_REDIR) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`else
    // Counter width only matters when statistics are built in.
    logic cnt_w_unused_s;
    assign cnt_w_unused_s = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven directed bench for pipe_ctrl, plus hand-written reset sequences.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam logic [7:0] C_RUN = 8'b1100_1100;
    localparam logic [7:0] C_HAZ = 8'b0001_1100;
    localparam logic [7:0] C_FRZ = 8'b0000_0000;
    localparam logic [7:0] C_RB  = 8'b1111_1101;
    localparam logic [7:0] C_RJ  = 8'b1111_1110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_id = OP_NOP;
    logic [4:0] rs_id = 5'd0, rt_id = 5'd0, rd_id = 5'd0;
    logic       ife_ex = 1'b0, mem_wait = 1'b0;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we;
    logic [1:0] pc_sel, state_o;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .ife_ex(ife_ex), .mem_wait(mem_wait), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .pc_sel(pc_sel), .state_o(state_o)
`ifdef PIPE_CTRL_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       ife, mw;
        logic [7:0] ctl;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic ife, input logic mw,
                       input logic [7:0] ctl, input logic [1:0] st);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.ife = ife; v.mw = mw; v.ctl = ctl; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic check_ctl(input string name, input logic [7:0] ctl, input logic [1:0] st);
        logic [9:0] act;
        act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, pc_sel, state_o};
        n_checks++;
        if (act === {ctl, st}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ctl=%b state=%0d, want ctl=%b state=%0d",
                     name, act[9:2], act[1:0], ctl, st);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        // op rs rt rd ife mw ctl state
        add(OP_ADD, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_SUB, 5'd3,  5'd4,  5'd6,  1'b0, 1'b0, C_HAZ, 2'd0);
        add(OP_SUB, 5'd3,  5'd4,  5'd6,  1'b0, 1'b0, C_HAZ, 2'd1);
        add(OP_SUB, 5'd3,  5'd4,  5'd6,  1'b0, 1'b0, C_RUN, 2'd1);
        add(OP_LW,  5'd1,  5'd5,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_AND, 5'd5,  5'd0,  5'd7,  1'b0, 1'b0, C_HAZ, 2'd0);
        add(OP_AND, 5'd5,  5'd0,  5'd7,  1'b0, 1'b0, C_HAZ, 2'd1);
        add(OP_AND, 5'd5,  5'd0,  5'd7,  1'b0, 1'b0, C_RUN, 2'd1);
        add(OP_ADD, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_OR,  5'd0,  5'd0,  5'd8,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_BEQ, 5'd2,  5'd9,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_XOR, 5'd8,  5'd1,  5'd10, 1'b1, 1'b0, C_RB,  2'd0);
        add(OP_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd2);
        add(OP_BEQ, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_ADD, 5'd1,  5'd2,  5'd11, 1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_JMP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_SUB, 5'd11, 5'd0,  5'd12, 1'b0, 1'b0, C_RJ,  2'd0);
        add(OP_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd2);
        add(OP_ADD, 5'd1,  5'd2,  5'd13, 1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b0, C_HAZ, 2'd0);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b1, C_FRZ, 2'd1);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b1, C_FRZ, 2'd3);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b1, C_FRZ, 2'd3);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b0, C_HAZ, 2'd3);
        add(OP_SUB, 5'd13, 5'd13, 5'd14, 1'b0, 1'b0, C_RUN, 2'd1);
        add(OP_JMP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);
        add(OP_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, C_FRZ, 2'd0);
        add(OP_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RJ,  2'd3);
        add(OP_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd2);
        add(OP_BEQ, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN, 2'd0);

        // In reset, even with mem_wait high, outputs are run-class.
        mem_wait = 1'b1;
        #2;
        check_ctl("reset_state", C_RUN, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_wait = 1'b0;

        foreach (vecs[i]) begin
            op_id = vecs[i].op; rs_id = vecs[i].rs; rt_id = vecs[i].rt; rd_id = vecs[i].rd;
            ife_ex = vecs[i].ife; mem_wait = vecs[i].mw;
            @(negedge clk);
            check_ctl($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].st);
            @(posedge clk);
            #1;
        end

`ifdef PIPE_CTRL_STATS_EN
        check_val("stall_cnt", stall_cnt, 32'd6);
        check_val("flush_cnt", flush_cnt, 32'd3);
`endif

        // BEQ now sits in EX; a taken result would redirect.
        op_id = OP_NOP; rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
        ife_ex = 1'b1;
        #1;
        check_ctl("beq_pending", C_RB, 2'd0);
        rst = 1'b1;
        #1;
        check_ctl("rst_mid_redirect", C_RUN, 2'd0);
`ifdef PIPE_CTRL_STATS_EN
        check_val("stall_cnt_rst", stall_cnt, 32'd0);
        check_val("flush_cnt_rst", flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_ctl("post_rst_no_redirect", C_RUN, 2'd0);
        @(posedge clk);
        #1;
        check_ctl("post_rst_next", C_RUN, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1);
    end

endmodule
